// File: rtl/mac_pkg.sv
// Shared MAC-subsystem constants and flattened-bus helpers for the
// partial-product alignment path.
package mac_pkg;

  localparam int PP_W_DEF    = 3;
  localparam int EXP_W_DEF   = 6;
  localparam int ALIGN_W_DEF = 15;
  localparam int MAG_W_DEF   = ALIGN_W_DEF - 1;

  // Widest flattened bus and widest lane the slice helper handles.
  localparam int BUS_MAX   = 256;
  localparam int SLICE_MAX = 32;

  function automatic logic [SLICE_MAX-1:0] lane_slice(
    input logic [BUS_MAX-1:0] bus,
    input int                 idx,
    input int                 w
  );
    logic [BUS_MAX-1:0] mask;
    mask = ~({BUS_MAX{1'b1}} << w);
    return SLICE_MAX'((bus >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/align_pp_pipe_if.sv
// Valid/ready bus between the partial-product generator, the aligner and
// the adder tree.
interface align_pp_pipe_if
  import mac_pkg::*;
#(
  parameter int N_LANE  = 4,
  parameter int PP_W    = PP_W_DEF,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int ALIGN_W = ALIGN_W_DEF
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [N_LANE-1:0]           in_sign;
  logic [N_LANE*PP_W-1:0]      in_mag;
  logic [N_LANE*EXP_W-1:0]     in_exp;
  logic [N_LANE-1:0]           in_zero;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_LANE*ALIGN_W-1:0]   align_pp;
  logic [N_LANE-1:0]           sticky;
  logic [EXP_W-1:0]            max_exp;

  modport master (
    output in_valid, in_sign, in_mag, in_exp, in_zero, out_ready,
    input  in_ready, out_valid, align_pp, sticky, max_exp
  );

  modport slave (
    input  in_valid, in_sign, in_mag, in_exp, in_zero, out_ready,
    output in_ready, out_valid, align_pp, sticky, max_exp
  );

endinterface

// File: rtl/align_lane.sv
// One lane of the aligner: right-shift a sign/magnitude partial product to
// the beat's maximum exponent, collect sticky, convert to two's complement.
module align_lane
  import mac_pkg::*;
#(
  parameter int PP_W    = PP_W_DEF,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int ALIGN_W = ALIGN_W_DEF
) (
  input  logic [EXP_W-1:0]          diff,
  input  logic [PP_W-1:0]           mag,
  input  logic                      sign,
  input  logic                      zero,
  output logic signed [ALIGN_W-1:0] lane,
  output logic                      sticky
);

  localparam int M = ALIGN_W - 1;

  function automatic logic signed [ALIGN_W-1:0] negate(input logic [ALIGN_W-1:0] v);
    return -$signed(v);
  endfunction

  logic [M-1:0]       ext;
  logic [M-1:0]       shifted;
  logic [M-1:0]       below;
  logic [ALIGN_W-1:0] mag_ext;

  always_comb begin
    ext     = {mag, {(M-PP_W){1'b0}}};
    shifted = '0;
    below   = '0;
    lane    = '0;
    sticky  = 1'b0;
    // Shifting by M or more empties the lane; every magnitude bit is lost.
    if (32'(diff) >= M) begin
      below = ext;
    end else begin
      shifted = ext >> diff;
      below   = ext & ~({M{1'b1}} << diff);
    end
    mag_ext = {1'b0, shifted};
    if (!zero) begin
      lane   = sign ? negate(mag_ext) : $signed(mag_ext);
      sticky = |below;
    end
  end

endmodule

// File: rtl/align_pp_pipe.sv
// Two-stage multi-lane partial-product aligner: max-exponent search in stage
// A, per-lane shift/sticky/negate in stage B, valid/ready on both ends.
module align_pp_pipe
  import mac_pkg::*;
#(
  parameter int N_LANE  = 4,
  parameter int PP_W    = PP_W_DEF,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int ALIGN_W = ALIGN_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  align_pp_pipe_if.slave bus
);

  logic                      vld_p0, vld_p1;
  logic                      adv_a, adv_b;
  logic [N_LANE-1:0]         sign_p0, zero_p0;
  logic [N_LANE*PP_W-1:0]    mag_p0;
  logic [N_LANE*EXP_W-1:0]   exp_p0;
  logic [EXP_W-1:0]          exp_l, max_in, max_p0, max_p1;
  logic [N_LANE*ALIGN_W-1:0] align_nxt, align_p1;
  logic [N_LANE-1:0]         sticky_nxt, sticky_p1;

  assign adv_b        = ~vld_p1 | bus.out_ready;
  assign adv_a        = ~vld_p0 | adv_b;
  assign bus.in_ready = adv_a;

  always_comb begin
    max_in = '0;
    exp_l  = '0;
    for (int i = 0; i < N_LANE; i++) begin
      exp_l = EXP_W'(lane_slice(BUS_MAX'(bus.in_exp), i, EXP_W));
      if (!bus.in_zero[i] && exp_l > max_in) max_in = exp_l;
    end
  end

  // Stage A: capture the beat and its maximum exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      sign_p0 <= '0;
      zero_p0 <= '0;
      mag_p0  <= '0;
      exp_p0  <= '0;
      max_p0  <= '0;
    end else if (adv_a) begin
      vld_p0 <= bus.in_valid;
      if (bus.in_valid) begin
        sign_p0 <= bus.in_sign;
        zero_p0 <= bus.in_zero;
        mag_p0  <= bus.in_mag;
        exp_p0  <= bus.in_exp;
        max_p0  <= max_in;
      end
    end
  end

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    logic [EXP_W-1:0]          diff;
    logic signed [ALIGN_W-1:0] lane;

    assign diff = max_p0 - EXP_W'(lane_slice(BUS_MAX'(exp_p0), g, EXP_W));

    align_lane #(
      .PP_W    (PP_W),
      .EXP_W   (EXP_W),
      .ALIGN_W (ALIGN_W)
    ) u_lane (
      .diff   (diff),
      .mag    (PP_W'(lane_slice(BUS_MAX'(mag_p0), g, PP_W))),
      .sign   (sign_p0[g]),
      .zero   (zero_p0[g]),
      .lane   (lane),
      .sticky (sticky_nxt[g])
    );

    assign align_nxt[g*ALIGN_W +: ALIGN_W] = lane;
  end

  // Stage B: register the aligned lanes for the adder tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      align_p1  <= '0;
      sticky_p1 <= '0;
      max_p1    <= '0;
    end else if (adv_b) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        align_p1  <= align_nxt;
        sticky_p1 <= sticky_nxt;
        max_p1    <= max_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.align_pp  = align_p1;
  assign bus.sticky    = sticky_p1;
  assign bus.max_exp   = max_p1;

endmodule

// File: tb/tb_align_pp_pipe.sv
// Directed and scoreboarded bench for align_pp_pipe: a 4-lane default
// instance for hand-computed vectors and an 8-lane, 20-bit instance.
module tb_align_pp_pipe;
  import mac_pkg::*;

  localparam int W = 160;

  typedef struct packed {
    logic [7:0]      sign;
    logic [7:0]      zero;
    logic [7:0][2:0] mag;
    logic [7:0][5:0] exp;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] align;
    logic [7:0]   st;
    logic [5:0]   mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  align_pp_pipe_if #(.N_LANE(4)) bus4 ();
  align_pp_pipe_if #(.N_LANE(8), .ALIGN_W(20)) bus8 ();

  align_pp_pipe #(.N_LANE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  align_pp_pipe #(.N_LANE(8), .ALIGN_W(20)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t q4[$];
  exp_t q8[$];
  int   out_cyc[$];
  exp_t m4, m8;
  logic [W-1:0] held4;
  bit   stall4 = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic beat_t set_lane(input beat_t b, input int i, input int mag,
                                     input int ex, input bit s, input bit z);
    b.mag[i]  = 3'(mag);
    b.exp[i]  = 6'(ex);
    b.sign[i] = s;
    b.zero[i] = z;
    return b;
  endfunction

  function automatic exp_t mk4(input logic [14:0] a0, input logic [14:0] a1,
                               input logic [14:0] a2, input logic [14:0] a3,
                               input logic [3:0] st, input logic [5:0] mx);
    exp_t e;
    e       = '0;
    e.align = W'({a3, a2, a1, a0});
    e.st    = 8'(st);
    e.mx    = mx;
    return e;
  endfunction

  // Integer reference: divide by 2^diff, remainder gives sticky, negate mod 2^ALIGN_W.
  function automatic exp_t model(input beat_t b, input int n, input int align_w);
    exp_t        e;
    int          m, diff;
    longint      ext, sh, modv;
    logic [63:0] lv;
    e    = '0;
    m    = align_w - 1;
    modv = longint'(1) << align_w;
    for (int i = 0; i < n; i++)
      if (!b.zero[i] && int'(b.exp[i]) > int'(e.mx)) e.mx = b.exp[i];
    for (int i = 0; i < n; i++) begin
      if (b.zero[i]) continue;
      diff = int'(e.mx) - int'(b.exp[i]);
      ext  = longint'(b.mag[i]) << (m - 3);
      if (diff >= m) begin
        sh       = 0;
        e.st[i]  = (b.mag[i] != 3'd0);
      end else begin
        sh       = ext / (longint'(1) << diff);
        e.st[i]  = (ext % (longint'(1) << diff)) != 0;
      end
      lv      = b.sign[i] ? 64'((modv - sh) % modv) : 64'(sh);
      e.align = e.align | (W'(lv) << (i * align_w));
    end
    return e;
  endfunction

  function automatic beat_t sb(input int j);
    beat_t b;
    b = '0;
    b = set_lane(b, 0, 4 + j % 4, j + 1, j[0], 1'b0);
    b = set_lane(b, 1, 7, j, 1'b0, 1'b0);
    b = set_lane(b, 2, 0, 0, 1'b0, 1'b1);
    b = set_lane(b, 3, 5, 0, 1'b1, 1'b0);
    return b;
  endfunction

  task automatic drive4(input beat_t b, input exp_t e, output bit acc);
    bus4.in_valid = 1'b1;
    bus4.in_sign  = b.sign[3:0];
    bus4.in_zero  = b.zero[3:0];
    bus4.in_mag   = b.mag[3:0];
    bus4.in_exp   = b.exp[3:0];
    @(negedge clk);
    acc = bus4.in_ready;
    if (acc) q4.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    bus4.in_valid = 1'b0;
    bus4.in_sign  = 4'($urandom);
    bus4.in_zero  = 4'($urandom);
    bus4.in_mag   = 12'($urandom);
    bus4.in_exp   = 24'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic drain4(input string tag);
    for (int i = 0; i < 30 && q4.size() != 0; i++) idle4();
    chk(tag, W'(q4.size()), W'(0));
  endtask

  task automatic drive8(input beat_t b, input exp_t e, output bit acc);
    bus8.in_valid  = 1'b1;
    bus8.in_sign   = b.sign;
    bus8.in_zero   = b.zero;
    bus8.in_mag    = b.mag;
    bus8.in_exp    = b.exp;
    bus8.out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    acc = bus8.in_ready;
    if (acc) q8.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall4 <= 1'b0;
    end else begin
      if (stall4)
        chk("hold4", W'({bus4.out_valid, bus4.max_exp, bus4.sticky, bus4.align_pp}), held4);
      if (bus4.out_valid) begin
        if (q4.size() == 0) begin
          chk("spurious4", W'(bus4.out_valid), W'(0));
        end else if (bus4.out_ready) begin
          m4 = q4.pop_front();
          chk("align4", W'(bus4.align_pp), m4.align);
          chk("sticky4", W'(bus4.sticky), W'(m4.st));
          chk("max4", W'(bus4.max_exp), W'(m4.mx));
          out_cyc.push_back(cyc);
        end
      end
      stall4 <= bus4.out_valid && !bus4.out_ready;
      held4  <= W'({bus4.out_valid, bus4.max_exp, bus4.sticky, bus4.align_pp});
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.out_valid) begin
      if (q8.size() == 0) begin
        chk("spurious8", W'(bus8.out_valid), W'(0));
      end else if (bus8.out_ready) begin
        m8 = q8.pop_front();
        chk("align8", W'(bus8.align_pp), m8.align);
        chk("sticky8", W'(bus8.sticky), W'(m8.st));
        chk("max8", W'(bus8.max_exp), W'(m8.mx));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b, db[5];
    exp_t  e, de[5];
    bit    acc;
    int    nacc, k;

    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    bus4.in_sign = '0; bus4.in_zero = '0; bus4.in_mag = '0; bus4.in_exp = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus8.in_sign = '0; bus8.in_zero = '0; bus8.in_mag = '0; bus8.in_exp = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(bus4.out_valid), W'(0));
    chk("rst_align", W'(bus4.align_pp), W'(0));
    chk("rst_sticky", W'(bus4.sticky), W'(0));
    chk("rst_max", W'(bus4.max_exp), W'(0));
    chk("rst_out_valid8", W'(bus8.out_valid), W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", W'(bus4.in_ready), W'(1));

    b = '0;
    b = set_lane(b, 0, 6, 10, 1'b0, 1'b0);
    b = set_lane(b, 1, 5, 8, 1'b1, 1'b0);
    b = set_lane(b, 2, 7, 63, 1'b1, 1'b1);
    b = set_lane(b, 3, 4, 0, 1'b0, 1'b0);
    db[0] = b; de[0] = mk4(15'h3000, 15'h7600, 15'h0000, 15'h0008, 4'b0000, 6'd10);
    b = '0;
    b = set_lane(b, 0, 6, 14, 1'b0, 1'b0);
    b = set_lane(b, 1, 5, 2, 1'b0, 1'b0);
    b = set_lane(b, 2, 4, 2, 1'b0, 1'b0);
    b = set_lane(b, 3, 5, 0, 1'b0, 1'b0);
    db[1] = b; de[1] = mk4(15'h3000, 15'h0002, 15'h0002, 15'h0000, 4'b1010, 6'd14);
    b = '0;
    b = set_lane(b, 0, 7, 20, 1'b1, 1'b0);
    b = set_lane(b, 1, 5, 0, 1'b1, 1'b0);
    b = set_lane(b, 2, 6, 6, 1'b1, 1'b0);
    b = set_lane(b, 3, 4, 7, 1'b1, 1'b0);
    db[2] = b; de[2] = mk4(15'h4800, 15'h0000, 15'h0000, 15'h7FFF, 4'b0110, 6'd20);
    b = '0;
    for (int i = 0; i < 4; i++) b = set_lane(b, i, 7, 63 - i, 1'b1, 1'b1);
    db[3] = b; de[3] = mk4(15'h0000, 15'h0000, 15'h0000, 15'h0000, 4'b0000, 6'd0);
    b = '0;
    b = set_lane(b, 0, 7, 63, 1'b0, 1'b0);
    b = set_lane(b, 1, 7, 0, 1'b0, 1'b0);
    b = set_lane(b, 2, 5, 50, 1'b1, 1'b0);
    b = set_lane(b, 3, 7, 1, 1'b0, 1'b1);
    db[4] = b; de[4] = mk4(15'h3800, 15'h0000, 15'h7FFF, 15'h0000, 4'b0110, 6'd63);

    drive4(db[0], de[0], acc);
    chk("acc_first", W'(acc), W'(1));
    bus4.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1", W'(bus4.out_valid), W'(0));
    @(negedge clk);
    chk("lat_edge2", W'(bus4.out_valid), W'(1));
    @(posedge clk);
    #1;
    drain4("drain_first");

    for (int i = 1; i < 5; i++) begin
      drive4(db[i], de[i], acc);
      chk("acc_directed", W'(acc), W'(1));
    end
    drain4("drain_directed");

    out_cyc.delete();
    for (int j = 0; j < 8; j++) begin
      b = sb(j);
      drive4(b, model(b, 4, 15), acc);
      chk("stream_acc", W'(acc), W'(1));
    end
    drain4("stream_drain");
    chk("stream_cnt", W'(out_cyc.size()), W'(8));
    if (out_cyc.size() == 8)
      chk("stream_consec", W'(out_cyc[7] - out_cyc[0]), W'(7));

    bus4.out_ready = 1'b0;
    nacc = 0;
    k    = 8;
    for (int c = 0; c < 5; c++) begin
      b = sb(k);
      drive4(b, model(b, 4, 15), acc);
      if (acc) begin
        nacc++;
        k++;
      end
    end
    chk("stall_acc", W'(nacc), W'(2));
    chk("stall_rdy", W'(bus4.in_ready), W'(0));
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      b = sb(k);
      drive4(b, model(b, 4, 15), acc);
      chk("release_acc", W'(acc), W'(1));
      k++;
    end
    drain4("release_drain");

    drive4(sb(1), model(sb(1), 4, 15), acc);
    drive4(sb(2), model(sb(2), 4, 15), acc);
    rst_n = 1'b0;
    q4.delete();
    bus4.in_valid = 1'b0;
    #1;
    chk("rst_flush_vld", W'(bus4.out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) begin
      idle4();
      chk("flushed_gone", W'(bus4.out_valid), W'(0));
    end
    drive4(db[0], de[0], acc);
    chk("acc_post_rst", W'(acc), W'(1));
    bus4.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_rst_edge1", W'(bus4.out_valid), W'(0));
    @(negedge clk);
    chk("lat_rst_edge2", W'(bus4.out_valid), W'(1));
    @(posedge clk);
    #1;
    drain4("drain_post_rst");

    for (int n = 0; n < 40; n++) begin
      b = '0;
      for (int i = 0; i < 8; i++)
        b = set_lane(b, i, $urandom_range(4, 7),
                     n[0] ? 40 + $urandom_range(0, 15) : $urandom_range(0, 63),
                     1'($urandom), $urandom_range(0, 3) == 0);
      e   = model(b, 8, 20);
      acc = 1'b0;
      for (int t = 0; t < 30 && !acc; t++) drive8(b, e, acc);
      chk("acc8", W'(acc), W'(1));
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 30 && q8.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain8", W'(q8.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
